// File: rtl/id_ex_operand_stage.sv
// Purpose: ID/EX pipeline register. Captures register-file operands with
//          same-cycle writeback bypass, detects load-use hazards, handles
//          execute stalls and branch flushes, counts hazard bubbles.
// Latency: one cycle from decode (id_stall=0) to the ex_* outputs.
// Backpressure: ex_stall holds every ID/EX field and raises id_stall;
//               a load-use hazard inserts one bubble and raises id_stall.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decoded instruction fields from decode
//   readData1/2                  register-file read data for id_rs1Sel/id_rs2Sel
//   wbWriteEn/RegSel/Data        writeback port (same signals as the register file)
//   ex_stall, flush              execute hold request, squash of the entering instr
//   ex_*                         ID/EX register contents presented to execute
//   id_stall                     decode/fetch must hold their instruction
//   stall_count                  saturating count of load-use bubbles
//   err                          simulation-only X/Z detector on control inputs
module id_ex_operand_stage #(
    parameter int          CTRL_W        = 8,
    // Saturation point of stall_count. Production value is all-ones; a lower
    // value only shortens scenarios that need to reach saturation.
    parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [2:0]        id_rs1Sel,
    input  logic [2:0]        id_rs2Sel,
    input  logic              id_rs1Used,
    input  logic              id_rs2Used,
    input  logic [2:0]        id_rd,
    input  logic              id_rdWrite,
    input  logic              id_isLoad,
    input  logic [15:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,

    input  logic [15:0]       readData1,
    input  logic [15:0]       readData2,

    input  logic              wbWriteEn,
    input  logic [2:0]        wbWriteRegSel,
    input  logic [15:0]       wbWriteData,

    input  logic              ex_stall,
    input  logic              flush,

    output logic              ex_valid,
    output logic [15:0]       ex_op1,
    output logic [15:0]       ex_op2,
    output logic [15:0]       ex_imm,
    output logic [2:0]        ex_rd,
    output logic              ex_rdWrite,
    output logic              ex_isLoad,
    output logic [CTRL_W-1:0] ex_ctrl,

    output logic              id_stall,
    output logic [15:0]       stall_count,
    output logic              err
);

    // ID/EX register state
    logic              ex_valid_q,   ex_valid_d;
    logic [15:0]       ex_op1_q,     ex_op1_d;
    logic [15:0]       ex_op2_q,     ex_op2_d;
    logic [15:0]       ex_imm_q,     ex_imm_d;
    logic [2:0]        ex_rd_q,      ex_rd_d;
    logic              ex_rdWrite_q, ex_rdWrite_d;
    logic              ex_isLoad_q,  ex_isLoad_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [15:0]       stall_cnt_q,  stall_cnt_d;

    logic [15:0]       byp1;
    logic [15:0]       byp2;
    logic              rs1_dep;
    logic              rs2_dep;
    logic              hazard;

    // Writeback bypass: the register file only updates at the edge, so a
    // write landing this cycle must be forwarded into the captured operand.
    // Register 0 is an ordinary register and is bypassed like any other.
    always_comb begin
        byp1 = readData1;
        byp2 = readData2;
        if (wbWriteEn && (wbWriteRegSel == id_rs1Sel)) begin
            byp1 = wbWriteData;
        end
        if (wbWriteEn && (wbWriteRegSel == id_rs2Sel)) begin
            byp2 = wbWriteData;
        end
    end

    // Load-use hazard: the load in EX has not produced its data yet. Bubbles
    // keep ex_isLoad/ex_rdWrite at 0, so the hazard clears after one bubble.
    always_comb begin
        rs1_dep  = id_rs1Used && (id_rs1Sel == ex_rd_q);
        rs2_dep  = id_rs2Used && (id_rs2Sel == ex_rd_q);
        hazard   = id_valid && ex_valid_q && ex_isLoad_q && ex_rdWrite_q
                   && (rs1_dep || rs2_dep);
        id_stall = ex_stall || hazard;
    end

    // Next-state selection; priority flush > ex_stall > hazard > issue.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        ex_imm_d     = ex_imm_q;
        ex_rd_d      = ex_rd_q;
        ex_rdWrite_d = ex_rdWrite_q;
        ex_isLoad_d  = ex_isLoad_q;
        ex_ctrl_d    = ex_ctrl_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush) begin
            // Squashed entry: payload fields are don't-care, so they hold.
            ex_valid_d   = 1'b0;
            ex_rdWrite_d = 1'b0;
            ex_isLoad_d  = 1'b0;
        end else if (ex_stall) begin
            // Hold everything; operands are not re-sampled. A writeback
            // completing now is seen later through the register file.
        end else if (hazard) begin
            ex_valid_d   = 1'b0;
            ex_rdWrite_d = 1'b0;
            ex_isLoad_d  = 1'b0;
            if (stall_cnt_q < STALL_CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            ex_valid_d   = id_valid;
            ex_op1_d     = byp1;
            ex_op2_d     = byp2;
            ex_imm_d     = id_imm;
            ex_rd_d      = id_rd;
            // Invalid entries must never look like a pending load/write.
            ex_rdWrite_d = id_valid && id_rdWrite;
            ex_isLoad_d  = id_valid && id_isLoad;
            ex_ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= 16'h0000;
            ex_op2_q     <= 16'h0000;
            ex_imm_q     <= 16'h0000;
            ex_rd_q      <= 3'd0;
            ex_rdWrite_q <= 1'b0;
            ex_isLoad_q  <= 1'b0;
            ex_ctrl_q    <= '0;
            stall_cnt_q  <= 16'h0000;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rd_q      <= ex_rd_d;
            ex_rdWrite_q <= ex_rdWrite_d;
            ex_isLoad_q  <= ex_isLoad_d;
            ex_ctrl_q    <= ex_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rdWrite  = ex_rdWrite_q;
    assign ex_isLoad   = ex_isLoad_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_cnt_q;

    // X/Z on any control input makes the reduction XOR unknown. Real
    // hardware never sees X, so this folds to constant 0 in silicon.
    assign err = ((^{id_valid, wbWriteEn, ex_stall, flush}) === 1'bx);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [15:0] SAT = 16'h0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs1Sel, id_rs2Sel;
    logic        id_rs1Used, id_rs2Used;
    logic [2:0]  id_rd;
    logic        id_rdWrite, id_isLoad;
    logic [15:0] id_imm;
    logic [7:0]  id_ctrl;
    logic [15:0] readData1, readData2;
    logic        wbWriteEn;
    logic [2:0]  wbWriteRegSel;
    logic [15:0] wbWriteData;
    logic        ex_stall, flush;
    logic        ex_valid;
    logic [15:0] ex_op1, ex_op2, ex_imm;
    logic [2:0]  ex_rd;
    logic        ex_rdWrite, ex_isLoad;
    logic [7:0]  ex_ctrl;
    logic        id_stall;
    logic [15:0] stall_count;
    logic        err;

    int total = 0;
    int bad   = 0;

    id_ex_operand_stage #(.CTRL_W(8), .STALL_CNT_MAX(SAT)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1Sel(id_rs1Sel), .id_rs2Sel(id_rs2Sel),
        .id_rs1Used(id_rs1Used), .id_rs2Used(id_rs2Used), .id_rd(id_rd),
        .id_rdWrite(id_rdWrite), .id_isLoad(id_isLoad), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .readData1(readData1), .readData2(readData2),
        .wbWriteEn(wbWriteEn), .wbWriteRegSel(wbWriteRegSel),
        .wbWriteData(wbWriteData), .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rdWrite(ex_rdWrite),
        .ex_isLoad(ex_isLoad), .ex_ctrl(ex_ctrl), .id_stall(id_stall),
        .stall_count(stall_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic        rst;  logic        vld;
        logic [2:0]  rs1;  logic [2:0]  rs2;
        logic        u1;   logic        u2;
        logic [2:0]  rd;   logic        rdw;  logic ld;
        logic [15:0] imm;  logic [7:0]  ctrl;
        logic [15:0] rd1;  logic [15:0] rd2;
        logic        wbe;  logic [2:0]  wbs;  logic [15:0] wbd;
        logic        stl;  logic        fl;
        // expected: id_stall this cycle, ex_* after the edge
        logic        e_stall; logic e_vld; logic chk_op;
        logic [15:0] e_op1;   logic [15:0] e_op2;
        logic        e_rdw;   logic e_ld;
        logic [15:0] e_cnt;   logic chk_pass;
    } vec_t;

    vec_t vecs[21];
    vec_t exp_q[$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; id_valid = v.vld;
        id_rs1Sel = v.rs1; id_rs2Sel = v.rs2;
        id_rs1Used = v.u1; id_rs2Used = v.u2;
        id_rd = v.rd; id_rdWrite = v.rdw; id_isLoad = v.ld;
        id_imm = v.imm; id_ctrl = v.ctrl;
        readData1 = v.rd1; readData2 = v.rd2;
        wbWriteEn = v.wbe; wbWriteRegSel = v.wbs; wbWriteData = v.wbd;
        ex_stall = v.stl; flush = v.fl;
    endtask

    // Drive one vector at negedge, check the combinational stall, queue the
    // registered expectation, then compare it just after the next posedge.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("v%0d id_stall", idx), {15'd0, id_stall}, {15'd0, v.e_stall});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d ex_valid", idx), {15'd0, ex_valid}, {15'd0, e.e_vld});
        check($sformatf("v%0d ex_rdWrite", idx), {15'd0, ex_rdWrite}, {15'd0, e.e_rdw});
        check($sformatf("v%0d ex_isLoad", idx), {15'd0, ex_isLoad}, {15'd0, e.e_ld});
        check($sformatf("v%0d stall_count", idx), stall_count, e.e_cnt);
        if (e.chk_op) begin
            check($sformatf("v%0d ex_op1", idx), ex_op1, e.e_op1);
            check($sformatf("v%0d ex_op2", idx), ex_op2, e.e_op2);
        end
        if (e.chk_pass) begin
            check($sformatf("v%0d ex_imm", idx), ex_imm, e.imm);
            check($sformatf("v%0d ex_rd", idx), {13'd0, ex_rd}, {13'd0, e.rd});
            check($sformatf("v%0d ex_ctrl", idx), {8'd0, ex_ctrl}, {8'd0, e.ctrl});
        end
    endtask

    initial begin
        vec_t   v;
        logic   exp_hz;
        logic [15:0] exp_cnt;

        //            rst vld rs1   rs2   u1 u2 rd    rdw ld imm       ctrl   rd1       rd2       wbe wbs   wbd       stl fl | stall vld chk op1     op2       rdw ld cnt       pass
        vecs[0]  = '{T, F, 3'd0, 3'd0, F, F, 3'd0, F, F, 16'h0000, 8'h00, 16'h0000, 16'h0000, F, 3'd0, 16'h0000, F, F,  F, F, T, 16'h0000, 16'h0000, F, F, 16'h0000, F};
        // plain issue
        vecs[1]  = '{F, T, 3'd2, 3'd5, T, T, 3'd1, T, F, 16'h0011, 8'hA5, 16'h1234, 16'h00FF, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h1234, 16'h00FF, T, F, 16'h0000, T};
        // writeback bypass into both operands
        vecs[2]  = '{F, T, 3'd3, 3'd3, T, T, 3'd6, T, F, 16'h0022, 8'h3C, 16'h0000, 16'h0000, T, 3'd3, 16'hBEEF, F, F,  F, T, T, 16'hBEEF, 16'hBEEF, T, F, 16'h0000, T};
        // bypass into R0 on rs1 only; this instruction is a load to R4
        vecs[3]  = '{F, T, 3'd0, 3'd7, T, T, 3'd4, T, T, 16'h0033, 8'h11, 16'hAAAA, 16'h5555, T, 3'd0, 16'h0F0F, F, F,  F, T, T, 16'h0F0F, 16'h5555, T, T, 16'h0000, T};
        // load-use on rs2=4: one bubble
        vecs[4]  = '{F, T, 3'd1, 3'd4, T, T, 3'd2, T, F, 16'h0044, 8'h22, 16'h1111, 16'h4444, F, 3'd0, 16'h0000, F, F,  T, F, F, 16'h0000, 16'h0000, F, F, 16'h0001, F};
        // dependent instruction issues the following cycle
        vecs[5]  = '{F, T, 3'd1, 3'd4, T, T, 3'd2, T, F, 16'h0044, 8'h22, 16'h1111, 16'h4444, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h1111, 16'h4444, T, F, 16'h0001, T};
        // load to R4 again
        vecs[6]  = '{F, T, 3'd0, 3'd0, F, F, 3'd4, T, T, 16'h0055, 8'h33, 16'h0000, 16'h0000, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h0000, 16'h0000, T, T, 16'h0001, T};
        // rs2=4 but not used: no hazard
        vecs[7]  = '{F, T, 3'd1, 3'd4, T, F, 3'd5, T, F, 16'h0066, 8'h44, 16'h0101, 16'h0202, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h0101, 16'h0202, T, F, 16'h0001, T};
        // load to R4 that does not write
        vecs[8]  = '{F, T, 3'd0, 3'd0, F, F, 3'd4, F, T, 16'h0077, 8'h55, 16'h0007, 16'h0008, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h0007, 16'h0008, F, T, 16'h0001, T};
        // uses R4 after non-writing load: no hazard; itself a load to R3
        vecs[9]  = '{F, T, 3'd2, 3'd4, T, T, 3'd3, T, T, 16'h0088, 8'h66, 16'h0909, 16'h0A0A, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h0909, 16'h0A0A, T, T, 16'h0001, F};
        // hazard together with ex_stall: hold, no bubble, count unchanged
        vecs[10] = '{F, T, 3'd3, 3'd0, T, F, 3'd7, T, F, 16'h0099, 8'h77, 16'h1313, 16'h0000, F, 3'd0, 16'h0000, T, F,  T, T, T, 16'h0909, 16'h0A0A, T, T, 16'h0001, F};
        // ex_stall alone, writeback to R0 must not leak into held operands
        vecs[11] = '{F, F, 3'd0, 3'd0, F, F, 3'd0, F, F, 16'h0000, 8'h00, 16'hAAAA, 16'hBBBB, T, 3'd0, 16'hDEAD, T, F,  T, T, T, 16'h0909, 16'h0A0A, T, T, 16'h0001, F};
        vecs[12] = '{F, F, 3'd0, 3'd0, F, F, 3'd0, F, F, 16'h0000, 8'h00, 16'hAAAA, 16'hBBBB, T, 3'd0, 16'hDEAD, T, F,  T, T, T, 16'h0909, 16'h0A0A, T, T, 16'h0001, F};
        // stall released: the hazard now produces a bubble
        vecs[13] = '{F, T, 3'd3, 3'd0, T, F, 3'd7, T, F, 16'h0099, 8'h77, 16'h1313, 16'h0000, F, 3'd0, 16'h0000, F, F,  T, F, F, 16'h0000, 16'h0000, F, F, 16'h0002, F};
        vecs[14] = '{F, T, 3'd3, 3'd0, T, F, 3'd7, T, F, 16'h0099, 8'h77, 16'h1313, 16'h0000, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h1313, 16'h0000, T, F, 16'h0002, T};
        // flush wins over ex_stall
        vecs[15] = '{F, T, 3'd1, 3'd2, T, T, 3'd1, T, T, 16'h00AA, 8'h88, 16'h2222, 16'h3333, F, 3'd0, 16'h0000, T, T,  T, F, F, 16'h0000, 16'h0000, F, F, 16'h0002, F};
        // flush alone does not raise id_stall
        vecs[16] = '{F, T, 3'd1, 3'd2, T, T, 3'd1, T, T, 16'h00AA, 8'h88, 16'h2222, 16'h3333, F, 3'd0, 16'h0000, F, T,  F, F, F, 16'h0000, 16'h0000, F, F, 16'h0002, F};
        // invalid decode forces rdWrite/isLoad low
        vecs[17] = '{F, F, 3'd0, 3'd0, F, F, 3'd4, T, T, 16'h0000, 8'h00, 16'h0001, 16'h0002, F, 3'd0, 16'h0000, F, F,  F, F, T, 16'h0001, 16'h0002, F, F, 16'h0002, F};
        vecs[18] = '{F, T, 3'd0, 3'd0, F, F, 3'd4, T, T, 16'h00BB, 8'h99, 16'h0000, 16'h0000, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h0000, 16'h0000, T, T, 16'h0002, T};
        // hazard with flush: squashed, not counted
        vecs[19] = '{F, T, 3'd4, 3'd0, T, F, 3'd1, T, F, 16'h00CC, 8'hAA, 16'h4444, 16'h0000, F, 3'd0, 16'h0000, F, T,  T, F, F, 16'h0000, 16'h0000, F, F, 16'h0002, F};
        vecs[20] = '{F, T, 3'd4, 3'd0, T, F, 3'd1, T, F, 16'h00CC, 8'hAA, 16'h4444, 16'h0000, F, 3'd0, 16'h0000, F, F,  F, T, T, 16'h4444, 16'h0000, T, F, 16'h0002, T};

        drive(vecs[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            apply(i, vecs[i]);
        end
        check("err low", {15'd0, err}, 16'h0000);

        // Back-to-back dependent loads: issue/bubble alternate, count saturates.
        v = vecs[20];
        v.rs1 = 3'd4; v.u1 = T; v.rs2 = 3'd0; v.u2 = F;
        v.rd = 3'd4; v.rdw = T; v.ld = T; v.fl = F; v.stl = F;
        v.rd1 = 16'h4040;
        exp_cnt = 16'h0002;
        for (int i = 0; i < 21; i++) begin
            exp_hz = (i % 2) == 1;
            @(negedge clk);
            drive(v);
            #1;
            check($sformatf("sat%0d id_stall", i), {15'd0, id_stall}, {15'd0, exp_hz});
            @(posedge clk);
            #1;
            if (exp_hz && exp_cnt < SAT) exp_cnt = exp_cnt + 16'd1;
            check($sformatf("sat%0d ex_valid", i), {15'd0, ex_valid}, {15'd0, ~exp_hz});
            check($sformatf("sat%0d stall_count", i), stall_count, exp_cnt);
        end
        check("saturated", stall_count, SAT);

        // Reset while a hazard is pending: everything clears.
        @(negedge clk);
        v.rst = T;
        drive(v);
        #1;
        check("rst hazard id_stall", {15'd0, id_stall}, 16'h0001);
        @(posedge clk);
        @(negedge clk);
        v.rst = F;
        drive(v);
        #1;
        check("rst ex_valid", {15'd0, ex_valid}, 16'h0000);
        check("rst ex_op1", ex_op1, 16'h0000);
        check("rst ex_op2", ex_op2, 16'h0000);
        check("rst ex_imm", ex_imm, 16'h0000);
        check("rst ex_rd", {13'd0, ex_rd}, 16'h0000);
        check("rst ex_rdWrite", {15'd0, ex_rdWrite}, 16'h0000);
        check("rst ex_isLoad", {15'd0, ex_isLoad}, 16'h0000);
        check("rst ex_ctrl", {8'd0, ex_ctrl}, 16'h0000);
        check("rst stall_count", stall_count, 16'h0000);
        check("rst id_stall", {15'd0, id_stall}, 16'h0000);
        check("rst err", {15'd0, err}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
